// File: rtl/aes128_io_pkg.sv
// Shared types and sizes for the AES-128 word-stream wrapper.
package aes128_io_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_ERR
  } state_e;

  // Element [WORDS_PER_BLOCK-1] occupies bits [127:96] and holds the first word of a block.
  typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] block_t;

endpackage

// File: rtl/aes128_word_ser.sv
// Serialises one 128-bit result block into four 32-bit words, first word = bits [127:96].
module aes128_word_ser
  import aes128_io_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  block_t            block_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              last_o
);

  block_t      data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        fire;

  assign fire   = valid_q && out_ready_i;
  assign last_o = fire && (idx_q == 2'(WORDS_PER_BLOCK - 1));

  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = block_i;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (fire) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'(WORDS_PER_BLOCK - 1)) begin
        valid_d = 1'b0;
        idx_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // The selected word only moves on an accepted transfer, so it holds steady under backpressure.
  assign out_valid_o = valid_q && !reset;
  assign out_data_o  = data_q[2'(WORDS_PER_BLOCK - 1) - idx_q];

endmodule

// File: rtl/aes128_word_io.sv
// 32-bit word stream wrapper around an external iterative AES-128 core.
// Optional counters blocks_done/run_cycles are built when AES128_WORD_IO_PERF_EN is defined.
module aes128_word_io
  import aes128_io_pkg::*;
#(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [BLOCK_W-1:0] key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               core_reset,
  output logic               core_ce,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [BLOCK_W-1:0] core_key,
  input  logic [BLOCK_W-1:0] core_data_out,
  input  logic               core_done,
  output logic               err
`ifdef AES128_WORD_IO_PERF_EN
  ,
  output logic [31:0]        blocks_done,
  output logic [7:0]         run_cycles
`endif
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  state_e             state_q, state_d;
  block_t             buf_q, buf_d;
  logic [2:0]         count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [BLOCK_W-1:0] core_data_q, core_key_q;
  logic               in_fire, launch, ser_load, ser_last, ser_valid;

  assign in_ready = !reset && (count_q < 3'(WORDS_PER_BLOCK)) && (state_q != ST_ERR);
  assign in_fire  = in_valid && in_ready;

  // Input buffer runs independently of the FSM; a launch clears it before any same-cycle write.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (launch) begin
      count_d = 3'd0;
    end
    if (in_fire) begin
      buf_d[2'(WORDS_PER_BLOCK - 1) - count_d[1:0]] = in_data;
      count_d = count_d + 3'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    launch   = 1'b0;
    ser_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q == 3'(WORDS_PER_BLOCK)) begin
          launch  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // core_done takes priority over the timeout on the final allowed cycle.
        if (core_done) begin
          ser_load = 1'b1;
          state_d  = ST_DRAIN;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_d == TW'(DONE_TIMEOUT)) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DRAIN: begin
        if (ser_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      count_q     <= 3'd0;
      timer_q     <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      timer_q <= timer_d;
      if (launch) begin
        core_data_q <= buf_q;
        core_key_q  <= key_in;
      end
    end
  end

  assign core_reset   = reset || (state_q == ST_START);
  assign core_ce      = !reset && ((state_q == ST_START) || (state_q == ST_RUN));
  assign core_data_in = core_data_q;
  assign core_key     = core_key_q;
  assign err          = !reset && (state_q == ST_ERR);

  aes128_word_ser u_ser (
    .clock       (clock),
    .reset       (reset),
    .load_i      (ser_load),
    .block_i     (core_data_out),
    .out_ready_i (out_ready),
    .out_valid_o (ser_valid),
    .out_data_o  (out_data),
    .last_o      (ser_last)
  );

  assign out_valid = ser_valid;

`ifdef AES128_WORD_IO_PERF_EN
  logic [31:0] blocks_q;
  logic [7:0]  run_q;

  // run_cycles reports the number of RUN cycles of the most recently finished block.
  always_ff @(posedge clock) begin
    if (reset) begin
      blocks_q <= 32'd0;
      run_q    <= 8'd0;
    end else begin
      if (ser_last) begin
        blocks_q <= blocks_q + 32'd1;
      end
      if ((state_q == ST_RUN) && core_done) begin
        run_q <= 8'(timer_q) + 8'd1;
      end
    end
  end

  assign blocks_done = blocks_q;
  assign run_cycles  = run_q;
`endif

endmodule

// File: tb/tb_aes128_word_io.sv
// Self-checking bench for aes128_word_io with a behavioural core and stream scoreboard.
module tb_aes128_word_io;

  localparam int DT = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [31:0]  in_data = '0;
  logic [127:0] key_in = '0;
  logic         in_ready, out_valid, core_reset, core_ce, core_done, err;
  logic [31:0]  out_data;
  logic [127:0] core_data_in, core_key, core_data_out;
`ifdef AES128_WORD_IO_PERF_EN
  logic [31:0]  blocks_done;
  logic [7:0]   run_cycles;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] inQ[$];
  logic [31:0] expQ[$];
  logic [31:0] gotLog[$];
  int          cyc = 0;
  int          errCyc = 0;
  int          blocksModel = 0;
  int          wordsOut = 0;
  bit          neverArmed = 0;
  bit          prevStall = 0;
  logic [31:0] prevData = '0;
  int          coreLat = 4;
  bit          neverDone = 0;
  bit          randOut = 0;
  int          coreCnt = 0;
  bit          coreRun = 0;
  logic [127:0] coreRes = '0;
  time         tAcc = 0;

  aes128_word_io #(.DONE_TIMEOUT(DT)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .key_in        (key_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .core_reset    (core_reset),
    .core_ce       (core_ce),
    .core_data_in  (core_data_in),
    .core_key      (core_key),
    .core_data_out (core_data_out),
    .core_done     (core_done),
    .err           (err)
`ifdef AES128_WORD_IO_PERF_EN
    ,
    .blocks_done   (blocks_done),
    .run_cycles    (run_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Stand-in for the external cipher: known FIPS-197 answer, otherwise a keyed mixing function.
  function automatic logic [127:0] coreFunc(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {d[119:0], d[127:120]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  always @(posedge clock) begin
    if (core_reset) begin
      coreCnt <= 0;
      coreRes <= coreFunc(core_data_in, core_key);
      coreRun <= 1'b1;
    end else if (core_ce && coreRun) begin
      coreCnt <= coreCnt + 1;
      if (core_done) coreRun <= 1'b0;
    end
  end

  assign core_done     = coreRun && !neverDone && (coreCnt == coreLat - 1);
  assign core_data_out = coreRes;

  always @(posedge clock) begin
    #1;
    if (randOut) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: words accepted in order form blocks, each launch must carry the next four words.
  always @(negedge clock) begin : monitor
    logic [127:0] blk, res;
    bit errExp;
    cyc++;
    if (reset) begin
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_core_ce", core_ce, 0);
      checkOutput("rst_core_reset", core_reset, 1);
      inQ.delete();
      expQ.delete();
      prevStall = 0;
      neverArmed = 0;
      blocksModel = 0;
      wordsOut = 0;
    end else begin
      if (core_reset) begin
        checkOutput("launch_has_block", 128'(inQ.size() >= 4), 1);
        if (inQ.size() >= 4) begin
          blk = {inQ[0], inQ[1], inQ[2], inQ[3]};
          repeat (4) void'(inQ.pop_front());
          checkOutput("core_data_in", core_data_in, blk);
          checkOutput("core_key", core_key, key_in);
          res = coreFunc(blk, key_in);
          for (int i = 0; i < 4; i++) expQ.push_back(res[127 - 32*i -: 32]);
          if (neverDone) begin
            neverArmed = 1;
            errCyc = cyc + 1 + DT;
          end
        end
      end
      errExp = neverArmed && (cyc >= errCyc);
      checkOutput("err", err, errExp);
      checkOutput("in_ready", in_ready, (inQ.size() < 4) && !errExp);
      if (in_valid && in_ready) inQ.push_back(in_data);
      if (prevStall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, prevData);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out", 1, 0);
        end else begin
          checkOutput("out_data", out_data, expQ.pop_front());
          gotLog.push_back(out_data);
          wordsOut++;
          if (wordsOut % 4 == 0) blocksModel++;
        end
      end
      prevStall = out_valid && !out_ready;
      prevData = out_data;
    end
  end

  task automatic applyStimulus(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = w;
    @(negedge clock);
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) checkOutput("in_accept_timeout", 0, 1);
    tAcc = $time;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendBlock(input logic [127:0] b);
    for (int i = 0; i < 4; i++) applyStimulus(b[127 - 32*i -: 32]);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clock);
    while ((expQ.size() != 0 || inQ.size() != 0 || out_valid) && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (n >= 600) checkOutput("drain_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] blk, res;
    int n;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_core_reset", core_reset, 0);
    @(posedge clock);
    #1;

    // FIPS-197 known answer plus idle latency.
    key_in = FIPS_KEY;
    coreLat = 5;
    gotLog.delete();
    sendBlock(FIPS_PT);
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("latency", 128'(($time - tAcc) / 10), 3 + 5);
    waitIdle();
    checkOutput("fips_count", gotLog.size(), 4);
    if (gotLog.size() >= 4) begin
      checkOutput("fips_w0", gotLog[0], 32'h69c4e0d8);
      checkOutput("fips_w1", gotLog[1], 32'h6a7b0430);
      checkOutput("fips_w2", gotLog[2], 32'hd8cdb780);
      checkOutput("fips_w3", gotLog[3], 32'h70b4c55a);
    end

    // core_done on the last permitted RUN cycle must beat the timeout.
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    coreLat = DT;
    sendBlock(128'h3243f6a8885a308d313198a2e0370734);
    waitIdle();
    checkOutput("boundary_err", err, 0);

    // Three blocks streamed back to back.
    coreLat = 3;
    gotLog.delete();
    for (int b = 0; b < 3; b++) sendBlock(128'h0123456789abcdeffedcba9876543210 ^ {4{32'(b * 32'h11111111)}});
    waitIdle();
    checkOutput("b2b_count", gotLog.size(), 12);

    // Random output backpressure.
    coreLat = 2;
    randOut = 1;
    sendBlock(128'hcafef00d_0badc0de_12345678_9abcdef0);
    sendBlock(128'h11223344_55667788_99aabbcc_ddeeff00);
    waitIdle();
    randOut = 0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
`ifdef AES128_WORD_IO_PERF_EN
    @(negedge clock);
    checkOutput("blocks_done", blocks_done, blocksModel);
    checkOutput("run_cycles", run_cycles, 2);
    @(posedge clock);
    #1;
`endif

    // Reset mid-RUN with two words of the next block queued.
    coreLat = 20;
    sendBlock(128'h55555555_66666666_77777777_88888888);
    n = 0;
    @(negedge clock);
    while (!(core_ce && !core_reset) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("reached_run", core_ce, 1);
    @(posedge clock);
    #1;
    applyStimulus(32'haaaa0001);
    applyStimulus(32'haaaa0002);
    pulseReset();
    @(negedge clock);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_core_ce", core_ce, 0);
    @(posedge clock);
    #1;
    coreLat = 4;
    gotLog.delete();
    blk = 128'h9999aaaa_bbbbcccc_ddddeeee_ffff0000;
    sendBlock(blk);
    waitIdle();
    res = coreFunc(blk, key_in);
    checkOutput("post_rst_count", gotLog.size(), 4);
    if (gotLog.size() >= 1) checkOutput("post_rst_w0", gotLog[0], res[127:96]);

    // Core never finishes: sticky error after DT RUN cycles.
    neverDone = 1;
    sendBlock(128'h01010101_02020202_03030303_04040404);
    n = 0;
    @(negedge clock);
    while (!err && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_in_ready", in_ready, 0);
    checkOutput("timeout_core_ce", core_ce, 0);
    checkOutput("timeout_out_valid", out_valid, 0);
    repeat (5) @(posedge clock);
    #1;
    pulseReset();
    neverDone = 0;
    @(negedge clock);
    checkOutput("err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
